gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Self-checking response monitor for combinational gate benches: the observing end of the stimulus/response loop. A stimulus driver presents input vectors to a gate under test. This block samples each vector with the gate's output and compares it against the expected Boolean function. It accumulates vector count, error count, input-space coverage and the first failing vector, then reports a single pass/fail verdict at end of run. It sits beside the gate under test in every gate-level bench, replacing manual waveform inspection.

## Interface
- N_IN, 2, gate input count (legal 1..4); coverage bitmap is 2^N_IN bits
- CNT_W, 8, width of vector and error counters

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse; begins a run (accepted in IDLE or DONE only)
- func  in  3  expected function, sampled on accepted start: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT vec_in[0], 111 BUF vec_in[0]
- vec_valid  in  1  vec_in/dut_out/vec_last valid this cycle
- vec_in  in  N_IN  input vector applied to gate under test
- dut_out  in  1  settled gate output for vec_in
- vec_last  in  1  qualifies final vector of run (with vec_valid)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid while done: err_cnt==0 and coverage complete
- vec_cnt  out  CNT_W  vectors checked this run, saturating
- err_cnt  out  CNT_W  mismatches this run, saturating
- fail_seen  out  1  at least one mismatch this run
- first_fail_vec  out  N_IN  vec_in of first mismatch
- first_fail_got  out  1  dut_out of first mismatch

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE --start--> RUN; DONE --start--> RUN; RUN --(vec_valid & vec_last)--> DONE. No other transitions.
- start in RUN ignored. vec_valid in IDLE/DONE ignored (no counter, coverage or capture change).
- Accepted start: latch func; clear vec_cnt, err_cnt, fail_seen, first_fail_*, coverage bitmap.
- Expected value, N_IN-bit reductions: AND = &vec_in, OR = |vec_in, XOR = ^vec_in, NAND/NOR/XNOR inverted; NOT/BUF use bit 0 only.
- Each accepted vector (RUN & vec_valid): vec_cnt += 1; coverage[vec_in] <= 1; on mismatch, err_cnt += 1.
- First mismatch only (fail_seen==0): capture vec_in, dut_out; set fail_seen. Later mismatches do not overwrite.
- Counters saturate at 2^CNT_W-1, never wrap.
- Last vector is checked like any other before entering DONE.
- pass = done & (err_cnt==0) & (all 2^N_IN coverage bits set); 0 outside DONE.
- Results hold in DONE until next accepted start or reset.
- Reset mid-run: all state cleared immediately, FSM to IDLE, no verdict.

## Timing
- Reset values: busy 0, done 0, pass 0, vec_cnt 0, err_cnt 0, fail_seen 0, first_fail_vec 0, first_fail_got 0.
- start at edge t -> busy=1 after edge t; first vector acceptable in the same cycle busy is high.
- Vector accepted at edge t -> vec_cnt/err_cnt/coverage/first_fail visible after edge t (1-cycle latency).
- Last vector at edge t -> busy=0, done=1, pass valid after edge t; counters include the last vector.
- start and vec_valid in the same cycle in IDLE: start taken, vector ignored.
- Back-to-back vectors every cycle supported; no backpressure.

## Test plan
- OR, N_IN=2: start, vectors 00,01,10,11 with correct outputs 0,1,1,1, last on 11 -> done=1, pass=1, vec_cnt=4, err_cnt=0.
- OR: same sweep, dut_out=0 on 01 and 10 -> err_cnt=2, fail_seen=1, first_fail_vec=01, first_fail_got=0, pass=0.
- AND, correct outputs, skip vector 10 -> err_cnt=0, coverage incomplete, pass=0.
- CNT_W=2: 6 failing vectors -> vec_cnt=3, err_cnt=3 (saturated), no wrap.
- Assert rst_n low after 2 vectors mid-run -> all outputs 0 immediately, IDLE; vec_valid afterward ignored until start.
- In DONE, vec_valid ignored (counts unchanged); new start with func=XOR clears results; exhaustive correct XOR sweep -> pass=1.

Source files
------------

// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between a gate bench driver and gate_response_checker.
// The master drives vectors and run control; the slave (checker) returns the verdict and statistics.
interface gate_response_checker_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       func;
    logic             vec_valid;
    logic [N_IN-1:0]  vec_in;
    logic             dut_out;
    logic             vec_last;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_seen;
    logic [N_IN-1:0]  first_fail_vec;
    logic             first_fail_got;

    modport master (
        output start, func, vec_valid, vec_in, dut_out, vec_last,
        input  busy, done, pass, vec_cnt, err_cnt, fail_seen, first_fail_vec, first_fail_got
    );

    modport slave (
        input  start, func, vec_valid, vec_in, dut_out, vec_last,
        output busy, done, pass, vec_cnt, err_cnt, fail_seen, first_fail_vec, first_fail_got
    );
endinterface

// File: rtl/gate_response_checker.sv
// Response monitor for combinational gate benches: checks each vector against the selected
// Boolean function and accumulates counts, input coverage and the first failing vector.
module gate_response_checker #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    gate_response_checker_if.slave bus
);
    localparam int COV_W = 1 << N_IN;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       func_q;
    logic [COV_W-1:0] cov;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_seen;
    logic [N_IN-1:0]  ff_vec;
    logic             ff_got;

    logic expected;
    logic accept;
    logic mismatch;
    logic start_ok;

    always_comb begin
        expected = 1'b0;
        case (func_q)
            3'b000:  expected = &bus.vec_in;
            3'b001:  expected = |bus.vec_in;
            3'b010:  expected = ~(&bus.vec_in);
            3'b011:  expected = ~(|bus.vec_in);
            3'b100:  expected = ^bus.vec_in;
            3'b101:  expected = ~(^bus.vec_in);
            3'b110:  expected = ~bus.vec_in[0];
            default: expected = bus.vec_in[0];
        endcase
    end

    // start wins over a same-cycle vector because acceptance requires RUN
    assign start_ok = bus.start && (state != RUN);
    assign accept   = (state == RUN) && bus.vec_valid;
    assign mismatch = accept && (bus.dut_out != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            func_q    <= '0;
            cov       <= '0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_seen <= 1'b0;
            ff_vec    <= '0;
            ff_got    <= 1'b0;
        end else if (start_ok) begin
            state     <= RUN;
            func_q    <= bus.func;
            cov       <= '0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_seen <= 1'b0;
            ff_vec    <= '0;
            ff_got    <= 1'b0;
        end else if (accept) begin
            if (vec_cnt != '1)
                vec_cnt <= vec_cnt + CNT_ONE;
            cov[bus.vec_in] <= 1'b1;
            if (mismatch) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + CNT_ONE;
                if (!fail_seen) begin
                    fail_seen <= 1'b1;
                    ff_vec    <= bus.vec_in;
                    ff_got    <= bus.dut_out;
                end
            end
            if (bus.vec_last)
                state <= DONE;
        end
    end

    assign bus.busy           = (state == RUN);
    assign bus.done           = (state == DONE);
    assign bus.pass           = (state == DONE) && (err_cnt == '0) && (&cov);
    assign bus.vec_cnt        = vec_cnt;
    assign bus.err_cnt        = err_cnt;
    assign bus.fail_seen      = fail_seen;
    assign bus.first_fail_vec = ff_vec;
    assign bus.first_fail_got = ff_got;
endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: directed scenarios plus randomized runs, checked against a
// truth-table reference model; a CNT_W=2 instance shares the same stimulus to exercise saturation.
module tb_gate_response_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_response_checker_if #(.N_IN(2), .CNT_W(8)) a ();
    gate_response_checker_if #(.N_IN(2), .CNT_W(2)) b ();

    assign b.start     = a.start;
    assign b.func      = a.func;
    assign b.vec_valid = a.vec_valid;
    assign b.vec_in    = a.vec_in;
    assign b.dut_out   = a.dut_out;
    assign b.vec_last  = a.vec_last;

    gate_response_checker #(.N_IN(2), .CNT_W(8)) dut_wide   (.clk(clk), .rst_n(rst_n), .bus(a));
    gate_response_checker #(.N_IN(2), .CNT_W(2)) dut_narrow (.clk(clk), .rst_n(rst_n), .bus(b));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    bit         m_run, m_done, m_fs, m_ffg;
    bit [2:0]   m_func;
    bit [1:0]   m_ffv;
    bit [3:0]   m_cov;
    int         m_cnt, m_err;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected gate output from the truth table, derived from the number of ones in the vector.
    function automatic bit ref_fn(input bit [2:0] f, input bit [1:0] v);
        int ones = $countones(v);
        case (f)
            3'd0:    return ones == 2;
            3'd1:    return ones > 0;
            3'd2:    return ones != 2;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            3'd6:    return v[0] == 1'b0;
            default: return v[0] == 1'b1;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_fs = 0; m_ffg = 0;
        m_func = '0; m_ffv = '0; m_cov = '0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, input bit [2:0] f, input bit v,
                              input bit [1:0] vec, input bit o, input bit l);
        if (st && !m_run) begin
            m_run = 1; m_done = 0; m_func = f;
            m_cnt = 0; m_err = 0; m_cov = '0; m_fs = 0; m_ffv = '0; m_ffg = 0;
        end else if (m_run && v) begin
            m_cnt++;
            m_cov[vec] = 1'b1;
            if (o != ref_fn(m_func, vec)) begin
                m_err++;
                if (!m_fs) begin m_fs = 1; m_ffv = vec; m_ffg = o; end
            end
            if (l) begin m_run = 0; m_done = 1; end
        end
    endtask

    task automatic check_all();
        bit exp_pass = m_done && (m_err == 0) && (m_cov == 4'hF);
        check("busy",       a.busy,           m_run);
        check("done",       a.done,           m_done);
        check("pass",       a.pass,           exp_pass);
        check("vec_cnt",    a.vec_cnt,        sat(m_cnt, 255));
        check("err_cnt",    a.err_cnt,        sat(m_err, 255));
        check("fail_seen",  a.fail_seen,      m_fs);
        check("ff_vec",     a.first_fail_vec, m_ffv);
        check("ff_got",     a.first_fail_got, m_ffg);
        check("n_vec_cnt",  b.vec_cnt,        sat(m_cnt, 3));
        check("n_err_cnt",  b.err_cnt,        sat(m_err, 3));
        check("n_pass",     b.pass,           exp_pass);
    endtask

    task automatic cycle(input bit st, input bit [2:0] f, input bit v,
                         input bit [1:0] vec, input bit o, input bit l);
        @(negedge clk);
        a.start = st; a.func = f; a.vec_valid = v; a.vec_in = vec; a.dut_out = o; a.vec_last = l;
        @(posedge clk);
        model_step(st, f, v, vec, o, l);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(0, 3'd0, 0, 2'd0, 0, 0);
    endtask

    // Sweep 00..11 with func f; bits set in err_mask flip the output, bits set in skip_mask are skipped.
    task automatic sweep(input bit [2:0] f, input bit [3:0] err_mask, input bit [3:0] skip_mask);
        cycle(1, f, 0, 2'd0, 0, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            if (!skip_mask[i])
                cycle(0, f, 1, 2'(i), ref_fn(f, 2'(i)) ^ err_mask[i], i == 3);
        end
    endtask

    initial begin
        a.start = 0; a.func = '0; a.vec_valid = 0; a.vec_in = '0; a.dut_out = 0; a.vec_last = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk); rst_n = 1'b1;
        idle();

        sweep(3'd1, 4'b0000, 4'b0000);          // OR, all correct -> pass
        idle();
        sweep(3'd1, 4'b0110, 4'b0000);          // OR, 01 and 10 wrong
        idle();
        sweep(3'd0, 4'b0000, 4'b0100);          // AND, 10 skipped -> coverage short
        idle();

        // six failing vectors: narrow instance saturates at 3
        cycle(1, 3'd2, 0, 2'd0, 0, 0);
        for (int unsigned i = 0; i < 6; i++)
            cycle(0, 3'd2, 1, 2'(i), ~ref_fn(3'd2, 2'(i)), i == 5);
        idle();

        // reset mid-run after two vectors
        cycle(1, 3'd4, 0, 2'd0, 0, 0);
        cycle(0, 3'd4, 1, 2'd1, 0, 0);
        cycle(0, 3'd4, 1, 2'd2, 1, 0);
        @(negedge clk); rst_n = 1'b0; #1;
        model_reset();
        check_all();
        @(negedge clk); rst_n = 1'b1;
        cycle(0, 3'd4, 1, 2'd3, 1, 1);          // ignored in IDLE
        cycle(1, 3'd5, 1, 2'd0, 0, 0);          // start + vector in IDLE: vector ignored
        cycle(1, 3'd0, 1, 2'd1, 0, 0);          // start in RUN ignored, vector accepted
        cycle(0, 3'd0, 1, 2'd3, 1, 1);
        cycle(0, 3'd0, 1, 2'd2, 0, 0);          // DONE: ignored
        sweep(3'd4, 4'b0000, 4'b0000);          // XOR restart clears, full pass
        idle();

        // randomized runs
        for (int unsigned r = 0; r < 60; r++) begin
            bit [2:0] f = 3'($urandom_range(0, 7));
            int unsigned len = $urandom_range(1, 12);
            cycle(1, f, $urandom_range(0, 1) == 1, 2'($urandom), 0, 0);
            for (int unsigned i = 0; i < len && m_run; i++) begin
                bit [1:0] v = 2'($urandom);
                bit flip = ($urandom_range(0, 7) == 0);
                cycle($urandom_range(0, 7) == 0, 3'($urandom), $urandom_range(0, 3) != 0,
                      v, ref_fn(m_func, v) ^ flip, i == len - 1);
            end
            if (m_run) begin
                bit [1:0] v = 2'($urandom);
                cycle(0, 3'd0, 1, v, ref_fn(m_func, v), 1);
            end
            for (int unsigned k = $urandom_range(0, 2); k > 0; k--)
                cycle(0, 3'($urandom), 1, 2'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
